// File: rtl/dual_issue_scheduler.sv
// dual_issue_scheduler: routes a fetched instruction pair onto the even/odd pipes,
// splitting conflicting pairs over two cycles, with flush, stall and issue counters.
module dual_issue_scheduler #(
    parameter logic [10:0] NOP_EVEN = 11'b01000000001,
    parameter logic [10:0] NOP_ODD  = 11'b00000000001,
    parameter int          CNT_W    = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             stall_in,
    input  logic             first_valid,
    input  logic             second_valid,
    input  logic [0:31]      first_inst,
    input  logic [0:31]      second_inst,
    input  logic             first_pipe,
    input  logic             second_pipe,
    input  logic [0:6]       first_rt,
    input  logic             first_wr,
    input  logic [0:20]      second_src,
    input  logic [0:2]       second_use,
    output logic [0:31]      even_inst,
    output logic [0:31]      odd_inst,
    output logic             even_valid,
    output logic             odd_valid,
    output logic             fetch_stall,
    output logic [CNT_W-1:0] dual_cnt,
    output logic [CNT_W-1:0] single_cnt
);
    localparam logic [0:31] NOP_E = {NOP_EVEN, 21'b0};
    localparam logic [0:31] NOP_O = {NOP_ODD, 21'b0};

    typedef enum logic {PAIR, SPLIT} state_t;

    state_t      state, state_n;
    logic [0:31] hold_inst, hold_inst_n, even_n, odd_n;
    logic        hold_pipe, hold_pipe_n, even_v_n, odd_v_n;
    logic        raw, conflict, upd;

    assign raw = first_wr && ((second_use[0] && second_src[0:6] == first_rt) ||
                              (second_use[1] && second_src[7:13] == first_rt) ||
                              (second_use[2] && second_src[14:20] == first_rt));
    assign conflict    = first_valid && second_valid && (first_pipe == second_pipe || raw);
    assign fetch_stall = !flush && (stall_in || (state == PAIR && conflict));
    assign upd         = !flush && !stall_in;

    always_comb begin
        state_n     = state;
        hold_inst_n = hold_inst;
        hold_pipe_n = hold_pipe;
        even_n      = even_inst;
        odd_n       = odd_inst;
        even_v_n    = even_valid;
        odd_v_n     = odd_valid;
        if (flush) begin
            state_n     = PAIR;
            hold_inst_n = '0;
            hold_pipe_n = 1'b0;
            even_n      = NOP_E;
            odd_n       = NOP_O;
            even_v_n    = 1'b0;
            odd_v_n     = 1'b0;
        end else if (!stall_in) begin
            even_n   = NOP_E;
            odd_n    = NOP_O;
            even_v_n = 1'b0;
            odd_v_n  = 1'b0;
            if (state == SPLIT) begin
                state_n = PAIR;
                if (hold_pipe) begin
                    odd_n   = hold_inst;
                    odd_v_n = 1'b1;
                end else begin
                    even_n   = hold_inst;
                    even_v_n = 1'b1;
                end
            end else begin
                if (first_valid && first_pipe) begin
                    odd_n   = first_inst;
                    odd_v_n = 1'b1;
                end else if (first_valid) begin
                    even_n   = first_inst;
                    even_v_n = 1'b1;
                end
                // a conflicting slot 1 waits in the holding reg for the next cycle
                if (conflict) begin
                    state_n     = SPLIT;
                    hold_inst_n = second_inst;
                    hold_pipe_n = second_pipe;
                end else if (second_valid && second_pipe) begin
                    odd_n   = second_inst;
                    odd_v_n = 1'b1;
                end else if (second_valid) begin
                    even_n   = second_inst;
                    even_v_n = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= PAIR;
            hold_inst  <= '0;
            hold_pipe  <= 1'b0;
            even_inst  <= NOP_E;
            odd_inst   <= NOP_O;
            even_valid <= 1'b0;
            odd_valid  <= 1'b0;
            dual_cnt   <= '0;
            single_cnt <= '0;
        end else begin
            state      <= state_n;
            hold_inst  <= hold_inst_n;
            hold_pipe  <= hold_pipe_n;
            even_inst  <= even_n;
            odd_inst   <= odd_n;
            even_valid <= even_v_n;
            odd_valid  <= odd_v_n;
            if (upd) begin
                dual_cnt   <= dual_cnt + CNT_W'(even_v_n & odd_v_n);
                single_cnt <= single_cnt + CNT_W'(even_v_n ^ odd_v_n);
            end
        end
    end
endmodule
